// File: rtl/intf_burst_src.sv
// Burst source: one start pulse emits BURST_LEN beats on a valid/ready stream,
// followed by an optional idle gap; the data pattern is chosen at elaboration.
module intf_burst_src #(
    parameter int PARAM      = 0,
    parameter int WIDTH      = 8,
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      done_count
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_beat;
    logic [GW-1:0]   r_gap;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic [15:0]     r_done;
    logic            w_accept;
    logic [BW-1:0]   w_beat_nxt;

    assign w_accept   = r_valid & out_ready;
    assign w_beat_nxt = r_beat + {{(BW-1){1'b0}}, 1'b1};

    // Burst sequencing FSM with registered handshake, status and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_BURST;
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (BURST_LEN == 1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (r_done != 16'hFFFF) begin
                                r_done <= r_done + 16'd1;
                            end
                            if (GAP_CYCLES > 0) begin
                                r_state <= ST_GAP;
                                r_gap   <= '0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_beat <= w_beat_nxt;
                            r_last <= (w_beat_nxt == BEAT_LAST);
                        end
                    end
                end
                ST_GAP: begin
                    // A start seen on the exit edge is dropped, not queued.
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign out_valid  = r_valid;
    assign out_last   = r_last;
    assign done_count = r_done;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("intf_burst_src: WIDTH must be >= 1");
        end
        if (BURST_LEN < 1) begin : g_bad_len
            $error("intf_burst_src: BURST_LEN must be >= 1");
        end
        if (GAP_CYCLES < 0) begin : g_bad_gap
            $error("intf_burst_src: GAP_CYCLES must be >= 0");
        end

        if (PARAM == 2) begin : g_incr
            logic [WIDTH-1:0] r_pat;
            // Running count survives across bursts; only reset clears it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pat <= '0;
                end else if (w_accept) begin
                    r_pat <= r_pat + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    r_pat <= r_pat;
                end
            end
            assign out_data = r_pat;
        end else if (PARAM == 3) begin : g_ones
            assign out_data = {WIDTH{r_valid}};
        end else if (PARAM == 0) begin : g_zero
            assign out_data = '0;
        end else begin : g_bad_param
            $error("intf_burst_src: PARAM must be 0, 2 or 3");
            assign out_data = '0;
        end
    endgenerate

endmodule
